// File: rtl/skew_transpose_buffer.sv
// Row-in / column-out transpose buffer: loads DIM rows, then drains lanes with optional diagonal
// skew (lane i delayed i steps). Vectors are flat; element k occupies bits [k*BITS +: BITS].
module skew_transpose_buffer #(
   parameter int unsigned BITS = 8,
   parameter int unsigned DIM  = 8,
   parameter int unsigned SKEW = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                row_valid,
   output logic                row_ready,
   input  logic [DIM*BITS-1:0] row_in,
   input  logic                start,
   input  logic                en,
   output logic [DIM*BITS-1:0] col_out,
   output logic                col_valid,
   output logic                full,
   output logic                done
);

   localparam int unsigned Steps = DIM + SKEW * (DIM - 1);
   localparam int unsigned RW    = $clog2(DIM);
   localparam int unsigned SW    = $clog2(Steps);

   typedef enum logic [1:0] {StLoad, StFull, StDrain} state_e;

   state_e              state_q;
   logic [RW-1:0]       row_cnt_q;
   logic [SW-1:0]       step_q;
   logic                done_q;
   logic [DIM*BITS-1:0] mem_q [DIM];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StLoad;
         row_cnt_q <= '0;
         step_q    <= '0;
         done_q    <= 1'b0;
         for (int r = 0; r < DIM; r++) mem_q[r] <= '0;
      end else begin
         done_q <= 1'b0;
         if (clr) begin
            state_q   <= StLoad;
            row_cnt_q <= '0;
            step_q    <= '0;
            for (int r = 0; r < DIM; r++) mem_q[r] <= '0;
         end else begin
            case (state_q)
               StLoad: begin
                  if (row_valid) begin
                     for (int r = 0; r < DIM; r++) begin
                        if (row_cnt_q == RW'(r)) mem_q[r] <= row_in;
                     end
                     if (row_cnt_q == RW'(DIM - 1)) begin
                        state_q   <= StFull;
                        row_cnt_q <= '0;
                     end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                     end
                  end
               end
               StFull: begin
                  if (start) begin
                     state_q <= StDrain;
                     step_q  <= '0;
                  end
               end
               StDrain: begin
                  if (en) begin
                     if (step_q == SW'(Steps - 1)) begin
                        state_q   <= StLoad;
                        row_cnt_q <= '0;
                        step_q    <= '0;
                        done_q    <= 1'b1;
                     end else begin
                        step_q <= step_q + 1'b1;
                     end
                  end
               end
               default: state_q <= StLoad;
            endcase
         end
      end
   end

   // Lane i shows column j of its row when step == j + SKEW*i; otherwise the lane reads zero.
   always_comb begin
      col_out = '0;
      if (state_q == StDrain) begin
         for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
               if (step_q == SW'(j + SKEW * i)) col_out[i*BITS +: BITS] = mem_q[i][j*BITS +: BITS];
            end
         end
      end
   end

   assign row_ready = (state_q == StLoad);
   assign full      = (state_q == StFull);
   assign col_valid = (state_q == StDrain) && en;
   assign done      = done_q;

endmodule

// File: tb/tb_skew_transpose_buffer.sv
// Bench for skew_transpose_buffer: one instance per skew mode (index = SKEW), each checked
// against a matrix model that derives every drain step from the lane/column offset rule.
module tb_skew_transpose_buffer;

   localparam int unsigned BITS = 8;
   localparam int unsigned DIM  = 4;
   localparam int unsigned W    = BITS * DIM;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   clr, row_valid, start, en;
   logic [1:0]   row_ready, col_valid, full, done;
   logic [W-1:0] row_in  [2];
   logic [W-1:0] col_out [2];

   logic [W-1:0] mm [2][DIM];
   int           held [2];
   int           n_chk = 0;
   int           n_pass = 0;

   always #5 clk = ~clk;

   skew_transpose_buffer #(.BITS(BITS), .DIM(DIM), .SKEW(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .row_valid(row_valid[0]),
      .row_ready(row_ready[0]), .row_in(row_in[0]), .start(start[0]), .en(en[0]),
      .col_out(col_out[0]), .col_valid(col_valid[0]), .full(full[0]), .done(done[0])
   );

   skew_transpose_buffer #(.BITS(BITS), .DIM(DIM), .SKEW(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .row_valid(row_valid[1]),
      .row_ready(row_ready[1]), .row_in(row_in[1]), .start(start[1]), .en(en[1]),
      .col_out(col_out[1]), .col_valid(col_valid[1]), .full(full[1]), .done(done[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] row4(input int a, input int b, input int c, input int d);
      logic [W-1:0] v;
      v = {d[7:0], c[7:0], b[7:0], a[7:0]};
      return v;
   endfunction

   // Lane i at step t carries M[i][t - k*i] when that column exists (k is the skew).
   function automatic logic [W-1:0] exp_col(input int k, input int t);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < DIM; i++) begin
         int j;
         j = t - k * i;
         if (j >= 0 && j < DIM) v[i*BITS +: BITS] = mm[k][i][j*BITS +: BITS];
      end
      return v;
   endfunction

   function automatic int steps_of(input int k);
      return DIM + k * (DIM - 1);
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin
         held[k] = 0;
         for (int r = 0; r < DIM; r++) mm[k][r] = '0;
      end
   endtask

   task automatic push(input int k, input logic v, input logic [W-1:0] d);
      @(negedge clk);
      row_valid[k] = v;
      row_in[k]    = d;
      #1;
      chk("row_ready", row_ready[k], held[k] < DIM);
      chk("full", full[k], held[k] == DIM);
      @(posedge clk);
      if (v && held[k] < DIM) begin
         mm[k][held[k]] = d;
         held[k]++;
      end
      #1 row_valid[k] = 1'b0;
   endtask

   task automatic load_rand(input int k);
      for (int n = 0; n < 64 && held[k] < DIM; n++)
         push(k, (n >= 32) || ($urandom_range(0, 2) != 0), $urandom());
   endtask

   task automatic load_directed(input int k);
      push(k, 1'b1, row4(1, 2, 3, 4));
      push(k, 1'b1, row4(5, 6, 7, 8));
      push(k, 1'b1, row4(9, 10, 11, 12));
      push(k, 1'b1, row4(13, 14, 15, 16));
   endtask

   task automatic drain(input int k, input int stall_at, input int stall_len, input bit rand_en,
                        input int abort_at);
      int t, ncv, stalled, steps;
      t = 0; ncv = 0; stalled = 0; steps = steps_of(k);
      @(negedge clk);
      start[k] = 1'b1;
      #1 chk("full_before_start", full[k], 1);
      @(posedge clk);
      #1 start[k] = 1'b0;
      for (int c = 0; c < 8 * steps + stall_len && t < steps; c++) begin
         @(negedge clk);
         if (rand_en) en[k] = ($urandom_range(0, 2) != 0);
         else if (t == stall_at && stalled < stall_len) begin
            en[k] = 1'b0;
            stalled++;
         end else en[k] = 1'b1;
         if (t == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_col_out", col_out[k], 0);
            chk("abort_col_valid", col_valid[k], 0);
            chk("abort_full", full[k], 0);
            chk("abort_ready", row_ready[k], 1);
            clear_model();
            @(negedge clk);
            rst_n = 1'b1;
            en[k] = 1'b0;
            repeat (3) begin
               @(negedge clk);
               #1 chk("abort_no_done", done[k], 0);
            end
            return;
         end
         #1;
         chk("col_valid", col_valid[k], en[k]);
         chk("col_out", col_out[k], exp_col(k, t));
         ncv += int'(col_valid[k]);
         @(posedge clk);
         if (en[k]) t++;
      end
      chk("drain_steps_reached", t, steps);
      chk("col_valid_count", ncv, steps);
      @(negedge clk);
      en[k] = 1'b0;
      #1;
      chk("done", done[k], 1);
      chk("ready_after_drain", row_ready[k], 1);
      chk("col_out_after_drain", col_out[k], 0);
      held[k] = 0;
      @(negedge clk);
      #1 chk("done_one_cycle", done[k], 0);
   endtask

   initial begin
      rst_n = 1'b0; clr = '0; row_valid = '0; start = '0; en = 2'b11;
      row_in[0] = '0; row_in[1] = '0;
      clear_model();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", row_ready[k], 1);
         chk("rst_full", full[k], 0);
         chk("rst_done", done[k], 0);
         chk("rst_col_valid", col_valid[k], 0);
         chk("rst_col_out", col_out[k], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en = '0;

      // Directed matrix, both skew modes.
      load_directed(1);
      drain(1, -1, 0, 1'b0, -1);
      load_directed(0);
      drain(0, -1, 0, 1'b0, -1);

      // Stall at step 2 for three cycles.
      load_directed(1);
      drain(1, 2, 3, 1'b0, -1);

      // Gapped row_valid, then row_valid while full must not disturb storage.
      push(1, 1'b1, $urandom());
      push(1, 1'b0, $urandom());
      push(1, 1'b1, $urandom());
      push(1, 1'b1, $urandom());
      push(1, 1'b0, $urandom());
      push(1, 1'b1, $urandom());
      push(1, 1'b1, $urandom());
      push(1, 1'b1, $urandom());
      drain(1, -1, 0, 1'b0, -1);

      // clr beats start in FULL; start in LOAD is ignored.
      load_rand(0);
      @(negedge clk);
      clr[0] = 1'b1; start[0] = 1'b1; en[0] = 1'b1;
      @(posedge clk);
      #1 clr[0] = 1'b0;
      for (int r = 0; r < DIM; r++) mm[0][r] = '0;
      held[0] = 0;
      @(negedge clk);
      #1;
      chk("clr_full", full[0], 0);
      chk("clr_ready", row_ready[0], 1);
      chk("clr_col_valid", col_valid[0], 0);
      chk("clr_col_out", col_out[0], 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("start_in_load_ready", row_ready[0], 1);
      chk("start_in_load_col_valid", col_valid[0], 0);
      start[0] = 1'b0; en[0] = 1'b0;
      load_rand(0);
      drain(0, -1, 0, 1'b0, -1);

      // Randomized data, row gaps and drain stalls.
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 2; k++) begin
            load_rand(k);
            drain(k, -1, 0, 1'b1, -1);
         end
      end

      // Asynchronous reset at drain step 4, then the directed run again.
      load_directed(1);
      drain(1, -1, 0, 1'b0, 4);
      load_directed(1);
      drain(1, -1, 0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/skew_transpose_buffer.md
SKEW_TRANSPOSE_BUFFER -- requirements
Module: skew_transpose_buffer

Interface
REQ-001 SHALL have parameter BITS, default 8, signed element width.
REQ-002 SHALL have parameter DIM, default 8, matrix dimension (rows = lanes = row length), DIM >= 2.
REQ-003 SHALL have parameter SKEW, default 1; 1 = diagonal skew (lane i delayed i steps), 0 = aligned.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous clear.
REQ-007 SHALL have port row_valid  input  1  row_in holds a valid row.
REQ-008 SHALL have port row_ready  output  1  block accepts a row this cycle.
REQ-009 SHALL have port row_in  input  DIM x BITS signed  row vector; element j = column j.
REQ-010 SHALL have port start  input  1  begin drain of a full matrix.
REQ-011 SHALL have port en  input  1  drain advance enable; low = stall.
REQ-012 SHALL have port col_out  output  DIM x BITS signed  output vector; element i = lane i.
REQ-013 SHALL have port col_valid  output  1  col_out is a valid drain step.
REQ-014 SHALL have port full  output  1  DIM rows held, awaiting start.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final drain step.

Function
REQ-016 SHALL hold a DIM x DIM storage matrix M; the row accepted r-th after entering LOAD is written to M[r][0..DIM-1].
REQ-017 SHALL implement states LOAD, FULL, DRAIN; reset state LOAD.
REQ-018 LOAD: row_ready = 1; a row is accepted on an edge with row_valid && row_ready; row counter increments 0..DIM-1.
REQ-019 LOAD -> FULL on the edge accepting row DIM-1; row_ready = 0 in FULL and DRAIN; row_valid there is ignored, no storage change.
REQ-020 FULL: full = 1; start on an edge -> DRAIN next cycle, step counter t = 0; start outside FULL is ignored.
REQ-021 DRAIN: total steps T = DIM + SKEW*(DIM-1); col_valid = en; t increments on each edge with en = 1.
REQ-022 At step t, col_out[i] = M[i][t - SKEW*i] when 0 <= t - SKEW*i < DIM, else 0; col_out is combinational from registered state and zero outside DRAIN.
REQ-023 en = 0 in DRAIN: t, col_out held, col_valid = 0.
REQ-024 On the edge consuming step T-1 (en = 1): -> LOAD, row counter = 0, done = 1 for the following cycle.
REQ-025 Storage content is retained after drain; rows written in the next LOAD overwrite it row by row.
REQ-026 clr = 1 on an edge: state LOAD, counters 0, storage zeroed, done = 0; clr has priority over row acceptance, start and en.
REQ-027 No arithmetic on data; elements pass bit-exact, sign preserved.

Reset
REQ-028 rst_n low SHALL immediately force state LOAD, counters 0, storage zero, col_out = 0, col_valid = 0, full = 0, done = 0, row_ready = 1 (once rst_n high).
REQ-029 Reset asserted mid-LOAD or mid-DRAIN SHALL abort; partial matrix discarded, no done pulse.

Verification (DIM=4, BITS=8)
REQ-030 SKEW=1, load rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16], start, en=1 -> step0 [1,0,0,0], step1 [2,5,0,0], step3 [4,7,10,13], step6 [0,0,0,16], done pulse next cycle, row_ready = 1.
REQ-031 SKEW=0, same rows -> 4 steps: [1,5,9,13], [2,6,10,14], [3,7,11,15], [4,8,12,16], then done.
REQ-032 SKEW=1, en low for 3 cycles at step 2 -> col_out held [3,6,9,0], col_valid 0, resumes at step 3; total col_valid count = 7.
REQ-033 row_valid toggled 1,0,1,1,0,1 in LOAD -> only 4 rows captured, full = 1 after the 4th; further row_valid in FULL -> row_ready 0, M unchanged.
REQ-034 clr asserted together with start in FULL -> LOAD, no DRAIN, M zero, full = 0; start during LOAD -> ignored.
REQ-035 rst_n pulsed low at drain step 4 -> outputs zero asynchronously, no done; subsequent load/drain matches REQ-030.
